wb_port_arbiter: RTL and testbench

- Shares the single register-file write port (WE3/A3/WD3) between the W-stage result and a long-latency unit such as the multiply/divide unit.
- The long-latency unit writes asynchronously to the pipeline.
- The W stage always has priority. Long-latency writes are queued in a small FIFO and drained into idle write-port cycles.
- Provides pending-register lookups to the hazard unit, plus a pipeline stall request.

---
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the W-stage
// result and a queued long-latency (mul/div) result stream.
// The W stage has priority. MDU results wait in a small FIFO and drain into
// idle write-port cycles. The FIFO also answers pending-register lookups for
// the hazard unit.
// Optional feature: define WB_STARVE_GUARD_EN to add a starve counter. When
// the W stage keeps the head entry blocked for STARVE_MAX cycles in a row, the
// arbiter requests a one-cycle pipeline stall (pipe_stall) so the head drains.
module wb_port_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_W,
    input  logic [4:0]  A3_W,
    input  logic [31:0] Result_W,
    input  logic        mdu_wr_valid,
    output logic        mdu_wr_ready,
    input  logic [4:0]  mdu_A3,
    input  logic [31:0] mdu_WD,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    output logic        pend_hit_1,
    output logic        pend_hit_2,
    output logic        pipe_stall,
    output logic        rf_WE,
    output logic [4:0]  rf_A3,
    output logic [31:0] rf_WD
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [4:0]    mem_a3 [DEPTH];
    logic [31:0]   mem_wd [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] idx;
    logic          pipe_w;
    logic          push;
    logic          pop;
    logic          hit1;
    logic          hit2;

    // A W-stage write to $0 is no write; a stall cycle also suppresses it.
    assign pipe_w = RegWrite_W && (A3_W != 5'd0) && !pipe_stall;

    // No pass-through: a full FIFO stays not-ready even in a pop cycle.
    assign mdu_wr_ready = !reset && (count < CW'(DEPTH));

    // Results aimed at $0 are acknowledged but never queued.
    assign push = mdu_wr_valid && mdu_wr_ready && (mdu_A3 != 5'd0);

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    logic [SW-1:0] starve;

    // Count consecutive cycles in which the W stage blocks a waiting head.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve <= '0;
        end else if (pop || (count == '0)) begin
            starve <= '0;
        end else if (pipe_w) begin
            starve <= starve + SW'(1);
        end
    end

    assign pipe_stall = !reset && (count != '0) && (starve == SW'(STARVE_MAX - 1));
`else
    assign pipe_stall = 1'b0;
`endif

    // Write-port mux: W result first, otherwise drain the FIFO head.
    always_comb begin
        rf_WE = 1'b0;
        rf_A3 = 5'd0;
        rf_WD = 32'd0;
        pop   = 1'b0;
        if (!reset) begin
            if (pipe_w) begin
                rf_WE = 1'b1;
                rf_A3 = A3_W;
                rf_WD = Result_W;
            end else if (count != '0) begin
                rf_WE = 1'b1;
                rf_A3 = mem_a3[rd_ptr];
                rf_WD = mem_wd[rd_ptr];
                pop   = 1'b1;
            end
        end
    end

    // Pending-register lookup over the currently valid entries only.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (mem_a3[idx] == A1_D) hit1 = 1'b1;
                if (mem_a3[idx] == A2_D) hit2 = 1'b1;
            end
        end
    end

    assign pend_hit_1 = !reset && (A1_D != 5'd0) && hit1;
    assign pend_hit_2 = !reset && (A2_D != 5'd0) && hit2;

    // FIFO storage; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a3[wr_ptr] <= mdu_A3;
            mem_wd[wr_ptr] <= mdu_WD;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PW.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model
// predicts each cycle's outputs; a monitor compares them at the falling edge.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_W;
    logic [4:0]  A3_W;
    logic [31:0] Result_W;
    logic        mdu_wr_valid;
    logic        mdu_wr_ready;
    logic [4:0]  mdu_A3;
    logic [31:0] mdu_WD;
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic        pend_hit_1;
    logic        pend_hit_2;
    logic        pipe_stall;
    logic        rf_WE;
    logic [4:0]  rf_A3;
    logic [31:0] rf_WD;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_W(RegWrite_W), .A3_W(A3_W), .Result_W(Result_W),
        .mdu_wr_valid(mdu_wr_valid), .mdu_wr_ready(mdu_wr_ready),
        .mdu_A3(mdu_A3), .mdu_WD(mdu_WD),
        .A1_D(A1_D), .A2_D(A2_D),
        .pend_hit_1(pend_hit_1), .pend_hit_2(pend_hit_2),
        .pipe_stall(pipe_stall),
        .rf_WE(rf_WE), .rf_A3(rf_A3), .rf_WD(rf_WD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        rdy;
        logic        h1;
        logic        h2;
        logic        stall;
    } exp_t;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
    } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];
    int   starve_m;
    int   n_assert;
    int   n_fail;
    bit   guard_on;

    // One cycle of stimulus: drive inputs, predict outputs, advance the model.
    task automatic step(input logic r, input logic rw, input logic [4:0] a3w,
                        input logic [31:0] res, input logic v, input logic [4:0] ma3,
                        input logic [31:0] mwd, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        int   sz;
        bit   pw;
        bit   popped;
        @(posedge clk);
        #1;
        reset = r; RegWrite_W = rw; A3_W = a3w; Result_W = res;
        mdu_wr_valid = v; mdu_A3 = ma3; mdu_WD = mwd; A1_D = a1; A2_D = a2;
        e = '{we: 1'b0, a3: 5'd0, wd: 32'd0, rdy: 1'b0, h1: 1'b0, h2: 1'b0, stall: 1'b0};
        popped = 1'b0;
        sz = mq.size();
        if (r) begin
            mq.delete();
            starve_m = 0;
        end else begin
            e.stall = guard_on && (sz > 0) && (starve_m == int'(STARVE_MAX) - 1);
            pw = rw && (a3w != 5'd0) && !e.stall;
            foreach (mq[i]) begin
                if (a1 != 5'd0 && mq[i].a3 == a1) e.h1 = 1'b1;
                if (a2 != 5'd0 && mq[i].a3 == a2) e.h2 = 1'b1;
            end
            e.rdy = (sz < int'(DEPTH));
            if (pw) begin
                e.we = 1'b1; e.a3 = a3w; e.wd = res;
            end else if (sz > 0) begin
                e.we = 1'b1; e.a3 = mq[0].a3; e.wd = mq[0].wd;
                void'(mq.pop_front());
                popped = 1'b1;
            end
            if (v && e.rdy && ma3 != 5'd0) mq.push_back('{a3: ma3, wd: mwd});
            if (popped || sz == 0) starve_m = 0;
            else if (pw) starve_m = starve_m + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_WE", 32'(rf_WE), 32'(e.we));
                check("rf_A3", 32'(rf_A3), 32'(e.a3));
                check("rf_WD", rf_WD, e.wd);
                check("mdu_wr_ready", 32'(mdu_wr_ready), 32'(e.rdy));
                check("pend_hit_1", 32'(pend_hit_1), 32'(e.h1));
                check("pend_hit_2", 32'(pend_hit_2), 32'(e.h2));
                check("pipe_stall", 32'(pipe_stall), 32'(e.stall));
            end
        end
    end

    initial begin
        int busy_pct;
`ifdef WB_STARVE_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
        n_assert = 0; n_fail = 0; starve_m = 0;
        reset = 1'b1; RegWrite_W = 1'b0; A3_W = 5'd0; Result_W = 32'd0;
        mdu_wr_valid = 1'b0; mdu_A3 = 5'd0; mdu_WD = 32'd0; A1_D = 5'd0; A2_D = 5'd0;

        // Reset with a result offered: nothing accepted, nothing written.
        repeat (2) step(1, 0, 0, 0, 1, 5'd5, 32'h1, 0, 0);

        // Idle W: pushed result drains next cycle; lookup hits only then.
        step(0, 0, 0, 0, 1, 5'd5, 32'h1234, 5'd5, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);

        // Busy W: entries 3 and 4 held, FIFO fills, then drain in order.
        step(0, 1, 5'd8, 32'h88, 1, 5'd3, 32'h33, 5'd3, 5'd4);
        step(0, 1, 5'd8, 32'h89, 1, 5'd4, 32'h44, 5'd3, 5'd4);
        step(0, 1, 5'd8, 32'h8a, 1, 5'd6, 32'h66, 5'd3, 5'd4);
        step(0, 1, 5'd8, 32'h8b, 0, 5'd0, 32'h0, 5'd3, 5'd4);
        repeat (3) step(0, 0, 0, 0, 0, 5'd0, 32'h0, 5'd3, 5'd4);

        // A W write to $0 frees the port for the queued entry.
        step(0, 1, 5'd8, 32'h8c, 1, 5'd9, 32'hABCD, 5'd9, 5'd0);
        step(0, 1, 5'd0, 32'hdead, 0, 5'd0, 32'h0, 5'd9, 5'd0);

        // Full FIFO with valid held: ready low in the pop cycle, then push.
        step(0, 1, 5'd8, 32'h1, 1, 5'd10, 32'hA0, 5'd10, 5'd11);
        step(0, 1, 5'd8, 32'h2, 1, 5'd11, 32'hB0, 5'd10, 5'd11);
        repeat (4) step(0, 0, 0, 0, 1, 5'd12, 32'hC0, 5'd12, 5'd11);
        repeat (2) step(0, 0, 0, 0, 0, 5'd0, 32'h0, 5'd12, 5'd0);

        // MDU result for $0 is acknowledged but never queued.
        step(0, 0, 0, 0, 1, 5'd0, 32'h77, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Long busy W with one entry queued (starvation scenario).
        step(0, 1, 5'd7, 32'h70, 1, 5'd2, 32'h22, 5'd2, 5'd7);
        for (int i = 0; i < 12; i++) step(0, 1, 5'd7, 32'(i), 0, 5'd0, 32'h0, 5'd2, 5'd7);

        // Randomized traffic with varying W-stage load.
        for (int blk = 0; blk < 40; blk++) begin
            busy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(1, 100) <= busy_pct),
                     5'($urandom_range(0, 7)), $urandom(),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end

        @(negedge clk);
        #1;
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
